// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 16-bit sequential ALU and its request driver:
//   - op-code constants (start/s/inbus/outbus/finish/overflow protocol)
//   - data width constant
//   - FSM state encoding of alu_req_driver
//   - helper telling whether an op returns two result words
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W = 16;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;
    localparam logic [1:0] ALU_DIV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_SEND1 = 3'd2,
        S_SEND2 = 3'd3,
        S_WAIT  = 3'd4,
        S_CAP2  = 3'd5,
        S_RESP  = 3'd6
    } drv_state_t;

    // mul returns {hi, lo}, div returns {remainder, quotient}: two finish words
    function automatic logic two_words(input logic [1:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_req_driver_if.sv
// ---------------------------------------------------------------------------
// alu_req_driver_if
// Bundles the three buses around alu_req_driver:
//   request  : req_valid/req_ready, req_op, req_a, req_b
//   response : rsp_valid/rsp_ready, rsp_lo, rsp_hi, rsp_ovf, rsp_err
//   ALU      : alu_start, alu_s, alu_inbus (to ALU); alu_outbus,
//              alu_finish, alu_overflow (from ALU)
// Modports:
//   master : the driver (it masters the ALU and answers the requester)
//   slave  : everything around it (control unit plus ALU)
// ---------------------------------------------------------------------------
interface alu_req_driver_if #(
    parameter int W = alu_pkg::ALU_W
);
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_lo;
    logic [W-1:0] rsp_hi;
    logic         rsp_ovf;
    logic         rsp_err;

    logic         alu_start;
    logic [1:0]   alu_s;
    logic [W-1:0] alu_inbus;
    logic [W-1:0] alu_outbus;
    logic         alu_finish;
    logic         alu_overflow;

    modport master (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
               alu_outbus, alu_finish, alu_overflow,
        output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_ovf, rsp_err,
               alu_start, alu_s, alu_inbus
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, rsp_ready,
               alu_outbus, alu_finish, alu_overflow,
        input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_ovf, rsp_err,
               alu_start, alu_s, alu_inbus
    );
endinterface

// File: rtl/alu_req_driver.sv
// ---------------------------------------------------------------------------
// alu_req_driver
// Takes a parallel {op, a, b} request, serialises it onto the sequential
// ALU (start pulse, then b, then a on inbus), waits for finish, captures one
// or two result words plus the overflow flag and holds them as a buffered
// response until the consumer accepts it.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_b : synchronous reset, active-high
//   bus     : alu_req_driver_if.master (request, response and ALU buses)
// Parameters:
//   W              : data/bus width
//   TIMEOUT_CYCLES : WAIT cycles before abort (only with ALU_DRV_TIMEOUT_EN)
// Optional feature macro: ALU_DRV_TIMEOUT_EN
//   defined   : WAIT aborts to RESP with rsp_err after TIMEOUT_CYCLES cycles
//   undefined : WAIT blocks until finish, no counter is built
// ---------------------------------------------------------------------------
module alu_req_driver
    import alu_pkg::*;
#(
    parameter int W              = ALU_W,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             i_clk,
    input  logic             i_rst_b,
    alu_req_driver_if.master bus
);

    drv_state_t   r_state, w_state_nxt;
    logic [1:0]   r_op;
    logic [W-1:0] r_a, r_b;
    logic [W-1:0] r_lo, r_hi;
    logic         r_ovf, r_err;

    logic         w_req_ready, w_rsp_valid, w_start;
    logic [1:0]   w_s;
    logic [W-1:0] w_inbus;
    logic         w_timeout;

`ifdef ALU_DRV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;

    // r_cnt counts completed WAIT cycles; the abort fires on the last
    // permitted WAIT cycle so RESP shows up TIMEOUT_CYCLES after WAIT entry
    always_ff @(posedge i_clk) begin
        if (i_rst_b)                 r_cnt <= '0;
        else if (r_state == S_SEND2) r_cnt <= '0;
        else if (r_state == S_WAIT)  r_cnt <= r_cnt + CW'(1);
    end

    assign w_timeout = (r_state == S_WAIT) && !bus.alu_finish &&
                       (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst_b) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // next state and decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_start     = 1'b0;
        w_s         = 2'b00;
        w_inbus     = '0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) w_state_nxt = S_START;
            end
            S_START: begin
                w_start     = 1'b1;
                w_s         = r_op;
                w_state_nxt = S_SEND1;
            end
            S_SEND1: begin
                w_s         = r_op;
                w_inbus     = r_b;          // right operand goes first
                w_state_nxt = S_SEND2;
            end
            S_SEND2: begin
                w_s         = r_op;
                w_inbus     = r_a;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_s = r_op;
                if (bus.alu_finish) begin
                    w_state_nxt = two_words(r_op) ? S_CAP2 : S_RESP;
                end else if (w_timeout) begin
                    w_s         = 2'b00;   // drop the op select on abort
                    w_state_nxt = S_RESP;
                end
            end
            S_CAP2: begin
                w_s         = r_op;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // request latch and response capture
    always_ff @(posedge i_clk) begin
        if (i_rst_b) begin
            r_op  <= 2'b00;
            r_a   <= '0;
            r_b   <= '0;
            r_lo  <= '0;
            r_hi  <= '0;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op  <= bus.req_op;
                        r_a   <= bus.req_a;
                        r_b   <= bus.req_b;
                        r_lo  <= '0;
                        r_hi  <= '0;
                        r_ovf <= 1'b0;
                        r_err <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (bus.alu_finish) begin
                        // overflow is only meaningful on the first word
                        r_ovf <= bus.alu_overflow;
                        if (two_words(r_op)) begin
                            r_hi <= bus.alu_outbus;
                        end else begin
                            r_lo <= bus.alu_outbus;
                            r_hi <= '0;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        r_lo  <= '0;
                        r_hi  <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                S_CAP2: begin
                    if (bus.alu_finish) begin
                        r_lo <= bus.alu_outbus;
                    end else begin
                        r_err <= 1'b1;     // second word missing
                        r_lo  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_lo    = r_lo;
    assign bus.rsp_hi    = r_hi;
    assign bus.rsp_ovf   = r_ovf;
    assign bus.rsp_err   = r_err;
    assign bus.alu_start = w_start;
    assign bus.alu_s     = w_s;
    assign bus.alu_inbus = w_inbus;

endmodule

// File: tb/tb_alu_req_driver.sv
// ---------------------------------------------------------------------------
// tb_alu_req_driver
// Directed bench for alu_req_driver: a behavioural sequential ALU answers the
// driver, expected responses (hand-computed) are queued at issue time and a
// monitor pops and compares them on every response handshake.
// ---------------------------------------------------------------------------
module tb_alu_req_driver;
    import alu_pkg::*;

    localparam int W  = 16;
    localparam int TO = 1023;

    typedef struct packed {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        ovf;
        logic        err;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    alu_req_driver_if #(.W(W)) bus ();

    alu_req_driver #(.W(W), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk   (clk),
        .i_rst_b (rst_b),
        .bus     (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    rsp_t sb_q[$];

    // ALU model controls and expected serialisation
    logic [1:0]  exp_op;
    logic [15:0] exp_a, exp_b;
    int          lat;
    bit          hang, drop2;
    int          wait_cyc;
    int          n_wait = 0;

    logic        m_fin, m_ovf, sp_fin;
    logic [15:0] m_out, sp_out;
    assign bus.alu_finish   = m_fin | sp_fin;
    assign bus.alu_outbus   = m_out | sp_out;
    assign bus.alu_overflow = m_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic rsp_t mk(input logic [15:0] lo, input logic [15:0] hi,
                                input logic ovf, input logic err);
        rsp_t r;
        r.lo = lo; r.hi = hi; r.ovf = ovf; r.err = err;
        return r;
    endfunction

    // behavioural sequential ALU: result = second word op first word
    initial begin
        logic [1:0]  op;
        logic [15:0] w1, w2, first, second, r;
        logic [31:0] prod;
        logic        ov;
        m_fin = 1'b0; m_out = '0; m_ovf = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.alu_start === 1'b1 && !rst_b) begin
                op = bus.alu_s;
                check("alu_s_start", {30'd0, op}, {30'd0, exp_op});
                check("inbus_start", {16'd0, bus.alu_inbus}, 32'd0);
                @(posedge clk); #1;
                w1 = bus.alu_inbus;
                check("start_pulse", {31'd0, bus.alu_start}, 32'd0);
                check("inbus_word1", {16'd0, w1}, {16'd0, exp_b});
                @(posedge clk); #1;
                w2 = bus.alu_inbus;
                check("inbus_word2", {16'd0, w2}, {16'd0, exp_a});
                @(posedge clk); #1;
                check("inbus_after", {16'd0, bus.alu_inbus}, 32'd0);
                check("alu_s_wait", {30'd0, bus.alu_s}, {30'd0, exp_op});
                wait_cyc = cyc;
                n_wait++;
                if (!hang) begin
                    repeat (lat) begin @(posedge clk); #1; end
                    ov = 1'b0; second = '0;
                    case (op)
                        ALU_ADD: begin r = w2 + w1; ov = (w2[15] == w1[15]) && (r[15] != w2[15]); first = r; end
                        ALU_SUB: begin r = w2 - w1; ov = (w2[15] != w1[15]) && (r[15] != w2[15]); first = r; end
                        ALU_MUL: begin prod = w2 * w1; first = prod[31:16]; second = prod[15:0]; end
                        default: begin first = w2 % w1; second = w2 / w1; end
                    endcase
                    m_fin = 1'b1; m_out = first; m_ovf = ov;
                    @(posedge clk); #1;
                    if (op[1]) begin
                        m_ovf = 1'b1;          // junk flag on the second word
                        if (drop2) begin
                            m_fin = 1'b0; m_out = '0;
                        end else begin
                            m_out = second;
                        end
                        @(posedge clk); #1;
                    end
                    m_fin = 1'b0; m_out = '0; m_ovf = 1'b0;
                end
            end
        end
    end

    // scoreboard monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_rsp: got lo=%0h hi=%0h expected none", bus.rsp_lo, bus.rsp_hi);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_lo",  {16'd0, bus.rsp_lo},  {16'd0, e.lo});
                    check("rsp_hi",  {16'd0, bus.rsp_hi},  {16'd0, e.hi});
                    check("rsp_ovf", {31'd0, bus.rsp_ovf}, {31'd0, e.ovf});
                    check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
                    check("req_ready_in_resp", {31'd0, bus.req_ready}, 32'd0);
                end
            end
        end
    end

    task automatic handshake(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        check("req_ready", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 3000) begin @(posedge clk); #1; n++; end
        check("rsp_drained", sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    task automatic do_req(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input rsp_t e, input int l, input bit d2, input bit chk_lat, input int hold);
        int n;
        exp_op = op; exp_a = a; exp_b = b; lat = l; drop2 = d2; hang = 1'b0;
        bus.rsp_ready = (hold == 0);
        sb_q.push_back(e);
        handshake(op, a, b);
        n = 1;
        while (bus.rsp_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        if (chk_lat) check("latency", n, 32'd5);
        repeat (hold) begin
            check("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("hold_lo", {16'd0, bus.rsp_lo}, {16'd0, e.lo});
            check("hold_hi", {16'd0, bus.rsp_hi}, {16'd0, e.hi});
            check("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        drain();
    endtask

    initial begin
        int n;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_a = '0; bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        sp_fin = 1'b0; sp_out = '0;
        hang = 1'b0; drop2 = 1'b0; lat = 0;
        exp_op = 2'b00; exp_a = '0; exp_b = '0;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;

        // reset state
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_alu_start", {31'd0, bus.alu_start}, 32'd0);
        check("rst_alu_s",     {30'd0, bus.alu_s},     32'd0);
        check("rst_inbus",     {16'd0, bus.alu_inbus}, 32'd0);
        check("rst_rsp_lo",    {16'd0, bus.rsp_lo},    32'd0);
        check("rst_rsp_err",   {31'd0, bus.rsp_err},   32'd0);

        // stray finish while idle must be ignored
        sp_fin = 1'b1; sp_out = 16'hffff;
        repeat (2) begin @(posedge clk); #1; end
        sp_fin = 1'b0; sp_out = '0;
        check("idle_ignore_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("idle_ignore_ready", {31'd0, bus.req_ready}, 32'd1);

        do_req(ALU_ADD, 16'd2147,  16'd5,     mk(16'd2152,   16'd0, 1'b0, 1'b0), 0, 1'b0, 1'b1, 0);
        do_req(ALU_SUB, 16'd2147,  16'd5,     mk(16'd2142,   16'd0, 1'b0, 1'b0), 2, 1'b0, 1'b0, 0);
        do_req(ALU_ADD, 16'd16389, 16'd16386, mk(16'h8007,   16'd0, 1'b1, 1'b0), 0, 1'b0, 1'b1, 0);
        do_req(ALU_SUB, 16'h8000,  16'd1,     mk(16'h7fff,   16'd0, 1'b1, 1'b0), 1, 1'b0, 1'b0, 0);
        do_req(ALU_MUL, 16'd2350,  16'd159,   mk(16'hB392,   16'h0005, 1'b0, 1'b0), 1, 1'b0, 1'b0, 0);
        do_req(ALU_DIV, 16'd18921, 16'd145,   mk(16'd130,    16'd71,   1'b0, 1'b0), 0, 1'b0, 1'b0, 10);
        // second word missing: error, lo cleared, hi kept
        do_req(ALU_MUL, 16'd2350,  16'd159,   mk(16'h0000,   16'h0005, 1'b0, 1'b1), 0, 1'b1, 1'b0, 0);

        // reset in the middle of a mul WAIT
        exp_op = ALU_MUL; exp_a = 16'd3; exp_b = 16'd4; hang = 1'b1;
        n = n_wait;
        handshake(ALU_MUL, 16'd3, 16'd4);
        begin
            int k;
            k = 0;
            while (n_wait == n && k < 50) begin @(posedge clk); #1; k++; end
            check("reached_wait", {31'd0, (n_wait != n)}, 32'd1);
        end
        repeat (3) begin @(posedge clk); #1; end
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        check("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("midrst_alu_s",     {30'd0, bus.alu_s},     32'd0);
        check("midrst_alu_start", {31'd0, bus.alu_start}, 32'd0);
        hang = 1'b0;

        // recovery after reset
        do_req(ALU_ADD, 16'd100, 16'd23, mk(16'd123, 16'd0, 1'b0, 1'b0), 0, 1'b0, 1'b1, 0);

`ifdef ALU_DRV_TIMEOUT_EN
        exp_op = ALU_MUL; exp_a = 16'd7; exp_b = 16'd9; hang = 1'b1;
        sb_q.push_back(mk(16'd0, 16'd0, 1'b0, 1'b1));
        handshake(ALU_MUL, 16'd7, 16'd9);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < TO + 100) begin @(posedge clk); #1; n++; end
        check("timeout_cycles", cyc - wait_cyc, TO);
        check("timeout_err", {31'd0, bus.rsp_err}, 32'd1);
        check("timeout_alu_s", {30'd0, bus.alu_s}, 32'd0);
        drain();
        hang = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
